// File: rtl/r5fp_pkg.sv
// Shared definitions for the FP mantissa back-end: FSM state encodings and
// the iteration-counter width helper.
package r5fp_pkg;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StBusy = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    // Bits needed to count up to w iterations.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/int_div_sqrt_iter.sv
// Iterative radix-2 restoring divider / square-root engine. One quotient or
// root bit is produced per clock; divide and sqrt share one trial subtractor.
module int_div_sqrt_iter
    import r5fp_pkg::*;
#(
    parameter int unsigned W = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] N_i,
    input  logic [W-1:0] D_i,
    input  logic         strobe_i,
    input  logic         is_div_i,
    output logic [W-1:0] Quo_o,
    output logic [W-1:0] Rem_o,
    output logic         done_o,
    output logic         ready_o
);

    localparam int unsigned CW = cnt_width(W);

    logic [1:0]    state_q;
    logic [CW-1:0] cnt_q;
    logic          is_div_q;
    logic          ovf_q;
    logic [W-1:0]  dvs_q;
    logic [W+1:0]  rad_q;   // radicand, consumed two bits at a time from the top
    logic [W+1:0]  rem_q;   // partial remainder
    logic [W-1:0]  q_q;     // partial quotient / root
    logic [W-1:0]  quo_q;
    logic [W-1:0]  rem_out_q;

    logic [W+1:0]  rem_in;
    logic [W+1:0]  opnd;
    logic [W+1:0]  diff;
    logic [W+1:0]  rem_nx;
    logic [W-1:0]  q_nx;
    logic          commit;
    logic          last;
    logic          start;

    assign ready_o = (state_q != StBusy);
    assign done_o  = (state_q == StDone);
    assign Quo_o   = quo_q;
    assign Rem_o   = rem_out_q;
    assign start   = strobe_i && ready_o;
    assign last    = (cnt_q == CW'(W - 1));

    // Trial subtraction step: divide subtracts D, sqrt subtracts {root, 01}.
    always_comb begin
        rem_in = '0;
        opnd   = '0;
        if (is_div_q) begin
            // The first divide step compares N itself (bit weight 2^(W-1)).
            rem_in = (cnt_q == '0) ? rem_q : (rem_q << 1);
            opnd   = {2'b00, dvs_q};
        end else begin
            rem_in = (rem_q << 2) | {{W{1'b0}}, rad_q[W+1:W]};
            opnd   = {q_q, 2'b01};
        end
        commit = (rem_in >= opnd);
        diff   = rem_in - opnd;
        rem_nx = commit ? diff : rem_in;
        q_nx   = {q_q[W-2:0], commit};
    end

    // FSM, operand capture and iteration registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            ovf_q     <= 1'b0;
            dvs_q     <= '0;
            rad_q     <= '0;
            rem_q     <= '0;
            q_q       <= '0;
            quo_q     <= '0;
            rem_out_q <= '0;
        end else if (start) begin
            state_q  <= StBusy;
            cnt_q    <= '0;
            is_div_q <= is_div_i;
            dvs_q    <= D_i;
            rad_q    <= {2'b00, D_i};
            rem_q    <= is_div_i ? {2'b00, N_i} : '0;
            q_q      <= '0;
            // Quotient would not fit in W bits: saturate at the end.
            ovf_q    <= is_div_i && ((D_i == '0) || ({1'b0, N_i} >= {D_i, 1'b0}));
        end else if (state_q == StBusy) begin
            rem_q <= rem_nx;
            q_q   <= q_nx;
            rad_q <= {rad_q[W-1:0], 2'b00};
            cnt_q <= cnt_q + 1'b1;
            if (last) begin
                state_q   <= StDone;
                quo_q     <= ovf_q ? '1 : q_nx;
                rem_out_q <= ovf_q ? '0 : rem_nx[W-1:0];
            end
        end else begin
            state_q <= StIdle;
        end
    end

endmodule

// File: tb/tb_int_div_sqrt_iter.sv
// Directed bench for int_div_sqrt_iter at W=8: reset state, divide and sqrt
// results, saturation, back-to-back starts, ignored strobes, mid-op reset.
module tb_int_div_sqrt_iter;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] N_i;
    logic [W-1:0] D_i;
    logic         strobe_i;
    logic         is_div_i;
    logic [W-1:0] Quo_o;
    logic [W-1:0] Rem_o;
    logic         done_o;
    logic         ready_o;

    int checks = 0;
    int errors = 0;
    int lat;

    int_div_sqrt_iter #(.W(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .N_i      (N_i),
        .D_i      (D_i),
        .strobe_i (strobe_i),
        .is_div_i (is_div_i),
        .Quo_o    (Quo_o),
        .Rem_o    (Rem_o),
        .done_o   (done_o),
        .ready_o  (ready_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Assert strobe for one edge, then scramble operands.
    task automatic start(input logic [W-1:0] n, input logic [W-1:0] d, input logic div);
        N_i      = n;
        D_i      = d;
        is_div_i = div;
        strobe_i = 1'b1;
        @(posedge clk);
        #1;
        strobe_i = 1'b0;
        N_i      = W'($urandom);
        D_i      = W'($urandom);
        is_div_i = 1'($urandom);
    endtask

    // Count edges until done_o is seen; -1 if the bound runs out.
    task automatic wait_done(output int k_out);
        k_out = -1;
        for (int k = 1; k <= int'(W) + 6; k++) begin
            @(posedge clk);
            #1;
            if (done_o) begin
                k_out = k;
                break;
            end
        end
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] n, input logic [W-1:0] d,
                         input logic div, input logic [W-1:0] eq, input logic [W-1:0] er);
        int l;
        start(n, d, div);
        check({tag, ".ready_busy"}, 32'(ready_o), 32'd0);
        wait_done(l);
        check({tag, ".latency"}, l, W);
        check({tag, ".quo"}, 32'(Quo_o), 32'(eq));
        check({tag, ".rem"}, 32'(Rem_o), 32'(er));
        check({tag, ".ready_done"}, 32'(ready_o), 32'd1);
        @(posedge clk);
        #1;
        check({tag, ".done_drop"}, 32'(done_o), 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        N_i      = '0;
        D_i      = '0;
        strobe_i = 1'b0;
        is_div_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.ready", 32'(ready_o), 32'd1);
        check("rst.done", 32'(done_o), 32'd0);
        check("rst.quo", 32'(Quo_o), 32'd0);
        check("rst.rem", 32'(Rem_o), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Divide: floor(N*128/D)
        do_op("div60_40", 8'h60, 8'h40, 1'b1, 8'hC0, 8'h00);
        do_op("div50_60", 8'h50, 8'h60, 1'b1, 8'h6A, 8'h40);
        do_op("div33_00", 8'h33, 8'h00, 1'b1, 8'hFF, 8'h00);
        do_op("div05_03", 8'h05, 8'h03, 1'b1, 8'hD5, 8'h01);
        do_op("div01_01", 8'h01, 8'h01, 1'b1, 8'h80, 8'h00);
        do_op("div7F_40", 8'h7F, 8'h40, 1'b1, 8'hFE, 8'h00);
        do_op("div80_40", 8'h80, 8'h40, 1'b1, 8'hFF, 8'h00);
        // Sqrt: X = D*64
        do_op("sqrt40", 8'h00, 8'h40, 1'b0, 8'h40, 8'h00);
        do_op("sqrtFF", 8'h00, 8'hFF, 1'b0, 8'h7F, 8'hBF);
        do_op("sqrt00", 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
        do_op("sqrt02", 8'h00, 8'h02, 1'b0, 8'h0B, 8'h07);
        do_op("sqrt01", 8'h00, 8'h01, 1'b0, 8'h08, 8'h00);

        // Back-to-back: strobe held during DONE.
        start(8'h50, 8'h60, 1'b1);
        wait_done(lat);
        check("b2b.first_lat", lat, W);
        check("b2b.first_quo", 32'(Quo_o), 32'h6A);
        start(8'h00, 8'hFF, 1'b0);
        check("b2b.ready_drop", 32'(ready_o), 32'd0);
        check("b2b.done_drop", 32'(done_o), 32'd0);
        check("b2b.quo_held", 32'(Quo_o), 32'h6A);
        check("b2b.rem_held", 32'(Rem_o), 32'h40);
        wait_done(lat);
        check("b2b.second_lat", lat, W);
        check("b2b.second_quo", 32'(Quo_o), 32'h7F);
        check("b2b.second_rem", 32'(Rem_o), 32'hBF);
        @(posedge clk);
        #1;

        // Strobe pulse mid-BUSY is ignored.
        start(8'h60, 8'h40, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        N_i      = 8'h01;
        D_i      = 8'h01;
        is_div_i = 1'b0;
        strobe_i = 1'b1;
        wait_done(lat);
        strobe_i = 1'b0;
        check("midstb.lat", lat, W - 3);
        check("midstb.quo", 32'(Quo_o), 32'hC0);
        check("midstb.rem", 32'(Rem_o), 32'h00);
        @(posedge clk);
        #1;

        // Reset at iteration 3 aborts the op.
        start(8'h05, 8'h03, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrst.ready", 32'(ready_o), 32'd1);
        check("midrst.done", 32'(done_o), 32'd0);
        check("midrst.quo", 32'(Quo_o), 32'd0);
        check("midrst.rem", 32'(Rem_o), 32'd0);
        wait_done(lat);
        check("midrst.no_done", lat, -1);

        // Engine still works after the abort.
        do_op("post_rst", 8'h50, 8'h60, 1'b1, 8'h6A, 8'h40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
